// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encoding and the default operand width.
package serial_addsub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unused; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sas_state_e;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Start/done handshake bundle between requester/consumer and the serial add/sub sequencer.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = serial_addsub_ctrl_pkg::DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    modport master (
        output start_valid, a, b, sub, done_ready,
        input  start_ready, result, cout, ovf, done_valid, busy
    );

    modport slave (
        input  start_valid, a, b, sub, done_ready,
        output start_ready, result, cout, ovf, done_valid, busy
    );
endinterface

// File: rtl/serial_addsub_ctrl_fa_bit_cell.sv
// One-bit full adder built from two half adders and an OR for the carry;
// the only arithmetic element the serial sequencer owns.
module fa_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic ha0_sum_s;
    logic ha0_carry_s;
    logic ha1_carry_s;

    fa_half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (ha0_sum_s),
        .carry (ha0_carry_s)
    );

    fa_half_adder u_ha1 (
        .a     (ha0_sum_s),
        .b     (cin),
        .sum   (sum),
        .carry (ha1_carry_s)
    );

    // Both half-adder carries can never be 1 together, so OR gives the majority.
    assign cout = ha0_carry_s | ha1_carry_s;
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: steps one full-adder cell LSB-first over
// WIDTH cycles between a start handshake and a done handshake.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_addsub_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sas_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic             c_q,      c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             dv_q,     dv_d;

    logic             fa_sum_s;
    logic             fa_cout_s;

    fa_bit_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (c_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next-state, datapath shifting and output decode for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        c_d      = c_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
                if (bus.start_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b ^ {WIDTH{bus.sub}};
                    c_d     = bus.sub;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_d            = result_q >> 1;
                result_d[WIDTH-1]   = fa_sum_s;
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                c_d                 = fa_cout_s;
                cnt_d               = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    ovf_d   = c_q ^ fa_cout_s;
                    cout_d  = fa_cout_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
        dv_d   = (state_d == ST_DONE);
    end

    // State, counter, operand shifters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            c_q      <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            c_q      <= c_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            dv_q     <= dv_d;
        end
    end

    // start_ready is a pure IDLE decode so it reads 1 while reset is held.
    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.busy        = busy_q;
    assign bus.done_valid  = dv_q;
    assign bus.result      = result_q;
    assign bus.cout        = cout_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed cases with literal
// expectations plus a randomized run against an arithmetic reference model.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: operation timing as a countdown, results from plain integer arithmetic.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_res  = '0;
    bit           m_cout = 1'b0;
    bit           m_ovf  = 1'b0;
    logic [W-1:0] p_res;
    bit           p_cout;
    bit           p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_res = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_done) begin
            if (bus.done_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else if (bus.start_valid) begin
            int sa, sb, r;
            sa = $signed(bus.a);
            sb = $signed(bus.b);
            if (bus.sub) begin
                r      = sa - sb;
                p_cout = (bus.a >= bus.b);
            end else begin
                r      = sa + sb;
                p_cout = ((int'(bus.a) + int'(bus.b)) >= (1 << W));
            end
            p_res  = W'(r);
            p_ovf  = (r > ((1 << (W-1)) - 1)) || (r < -(1 << (W-1)));
            m_left = W;
        end
    end

    // Per-cycle comparison against the model; result fields only outside RUN.
    always @(negedge clk) begin
        chk("start_ready", bus.start_ready, (m_left == 0) && !m_done);
        chk("busy", bus.busy, (m_left != 0) || m_done);
        chk("done_valid", bus.done_valid, m_done);
        if (m_left == 0) begin
            chk("result", bus.result, m_res);
            chk("cout", bus.cout, m_cout);
            chk("ovf", bus.ovf, m_ovf);
        end
    end

    task automatic finish_op(input string nm, input logic [W-1:0] er, input logic ec, input logic eo);
        int k = 0;
        while (!bus.done_valid && k < 20) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.sub = 1'($urandom);
            @(posedge clk); #2;
            k++;
        end
        chk({nm, " latency"}, k, W);
        chk({nm, " result"}, bus.result, er);
        chk({nm, " cout"}, bus.cout, ec);
        chk({nm, " ovf"}, bus.ovf, eo);
        chk({nm, " model result"}, m_res, er);
        chk({nm, " model cout"}, m_cout, ec);
        chk({nm, " model ovf"}, m_ovf, eo);
        if (bus.done_ready) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic [W-1:0] er, input logic ec, input logic eo);
        bus.a = ta; bus.b = tb_v; bus.sub = ts; bus.start_valid = 1'b1;
        @(posedge clk); #2;
        bus.start_valid = 1'b0;
        finish_op(nm, er, ec, eo);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.done_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset start_ready", bus.start_ready, 1'b1);
        chk("reset done_valid", bus.done_valid, 1'b0);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset result", bus.result, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        do_op("add 5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        do_op("add FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("sub 10-20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        do_op("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        do_op("add 01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Backpressure with a pending start held through DONE.
        bus.done_ready = 1'b0;
        do_op("bp 5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("bp hold result", bus.result, 8'h96);
            chk("bp hold start_ready", bus.start_ready, 1'b0);
            chk("bp hold done_valid", bus.done_valid, 1'b1);
        end
        bus.done_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp idle start_ready", bus.start_ready, 1'b1);
        @(posedge clk); #2;
        bus.start_valid = 1'b0;
        chk("bp accepted busy", bus.busy, 1'b1);
        finish_op("bp 11+22", 8'h33, 1'b0, 1'b0);

        // Reset in the middle of RUN.
        bus.a = 8'h01; bus.b = 8'h02; bus.sub = 1'b0; bus.start_valid = 1'b1;
        @(posedge clk); #2;
        bus.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst result", bus.result, 8'h00);
        chk("midrst cout", bus.cout, 1'b0);
        chk("midrst ovf", bus.ovf, 1'b0);
        chk("midrst done_valid", bus.done_valid, 1'b0);
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst start_ready", bus.start_ready, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        do_op("post-rst 7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Randomized traffic; operands are X whenever no start is offered.
        for (int i = 0; i < 800; i++) begin
            bus.start_valid = 1'($urandom);
            bus.a           = bus.start_valid ? W'($urandom) : 'x;
            bus.b           = bus.start_valid ? W'($urandom) : 'x;
            bus.sub         = 1'($urandom);
            bus.done_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        repeat (W + 4) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
